dram_word_responder: RTL

- Responder end of the external-DRAM request interface: accepts single-cycle 32-bit word read/write requests from the memory controller and returns a one-cycle ack with read data.
- Each word access executes as up to two 16-bit phases on an external 16-bit memory bus (PSRAM/async-SRAM style) with programmable wait states and turnaround.
- Sits at the top level between the memory controller's ext_dram_* port and the board memory pins.

---
 rtl/dram_word_responder_pkg.sv | 22 ++
 rtl/mem16_phase_timer.sv | 31 +++
 rtl/dram_word_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_word_responder_pkg.sv
// Shared types and constants for the 32-bit word responder that drives a
// 16-bit external memory bus.
package dram_word_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        GAP,
        DONE
    } state_t;

    localparam logic HALF_LOW  = 1'b0;
    localparam logic HALF_HIGH = 1'b1;

    typedef logic [15:0] halfword_t;

    // Little-endian: half 0 carries bits [15:0] of the word.
    function automatic halfword_t select_half(input logic [31:0] word, input logic half);
        return (half == HALF_HIGH) ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/mem16_phase_timer.sv
// Loadable down-counter that times both the strobe phase and the turnaround gap.
// done is high whenever the count has reached zero; it never wraps.
module mem16_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // A load always wins so the FSM can restart timing on every state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (sync_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/dram_word_responder.sv
// Responder for single-cycle 32-bit word requests: each access becomes up to
// two 16-bit phases on the external bus, with wait states and turnaround.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module dram_word_responder
    import dram_word_responder_pkg::*;
#(
    parameter int ADDR_BITS   = `MEM_ADDR_BITS,
    parameter int WAIT_STATES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic [ADDR_BITS-1:0] ext_dram_mem_addr,
    input  logic                 ext_dram_mem_read_en,
    input  logic                 ext_dram_mem_write_en,
    input  logic [3:0]           ext_dram_mem_byte_enable,
    input  logic [31:0]          ext_dram_mem_write_data,
    output logic                 ext_dram_ack,
    output logic [31:0]          ext_dram_mem_read_data,
    output logic                 busy,
    output logic                 req_overrun,
    output logic [ADDR_BITS:0]   mem16_addr,
    output logic                 mem16_cs_n,
    output logic                 mem16_oe_n,
    output logic                 mem16_we_n,
    output logic [1:0]           mem16_be_n,
    output halfword_t            mem16_dout,
    output logic                 mem16_dout_en,
    input  halfword_t            mem16_din
);

    localparam int CNT_W = $clog2(WAIT_STATES + TURNAROUND + 1);
    localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(WAIT_STATES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic                   write_q;
    logic                   half_q;
    logic                   second_q;
    logic [31:0]            hold_q;
    logic [31:0]            read_data_q;
    logic                   overrun_q;

    logic                   strobe;
    logic                   req_low;
    logic                   req_high;
    logic                   timer_load;
    logic [CNT_W-1:0]       timer_value;
    logic                   timer_done;
    logic                   advance;

    // Write wins when both strobes arrive; reads always touch both halves.
    assign strobe   = ext_dram_mem_read_en | ext_dram_mem_write_en;
    assign req_low  = ~ext_dram_mem_write_en | (|ext_dram_mem_byte_enable[1:0]);
    assign req_high = ~ext_dram_mem_write_en | (|ext_dram_mem_byte_enable[3:2]);

    mem16_phase_timer #(
        .WIDTH(CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (sync_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, timer reloads and the bus strobes, all decoded from the current state.
    always_comb begin
        state_next    = state;
        timer_load    = 1'b0;
        timer_value   = ACCESS_LOAD;
        advance       = 1'b0;
        mem16_cs_n    = 1'b1;
        mem16_oe_n    = 1'b1;
        mem16_we_n    = 1'b1;
        mem16_be_n    = 2'b11;
        mem16_dout    = '0;
        mem16_dout_en = 1'b0;

        case (state)
            IDLE: begin
                if (strobe) begin
                    if (req_low | req_high) begin
                        state_next = ACCESS;
                        timer_load = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ACCESS: begin
                mem16_cs_n = 1'b0;
                if (write_q) begin
                    mem16_we_n    = 1'b0;
                    mem16_dout_en = 1'b1;
                    mem16_dout    = select_half(wdata_q, half_q);
                    mem16_be_n    = (half_q == HALF_HIGH) ? ~be_q[3:2] : ~be_q[1:0];
                end else begin
                    mem16_oe_n = 1'b0;
                    mem16_be_n = 2'b00;
                end
                if (timer_done) begin
                    if (TURNAROUND > 0) begin
                        state_next  = GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end else if (second_q) begin
                        state_next = ACCESS;
                        timer_load = 1'b1;
                        advance    = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            GAP: begin
                if (timer_done) begin
                    if (second_q) begin
                        state_next = ACCESS;
                        timer_load = 1'b1;
                        advance    = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture; the half pointer only moves on entry to the second phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            half_q   <= HALF_LOW;
            second_q <= 1'b0;
        end else if (sync_reset) begin
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            half_q   <= HALF_LOW;
            second_q <= 1'b0;
        end else if (state == IDLE && strobe) begin
            addr_q   <= ext_dram_mem_addr;
            be_q     <= ext_dram_mem_byte_enable;
            wdata_q  <= ext_dram_mem_write_data;
            write_q  <= ext_dram_mem_write_en;
            half_q   <= req_low ? HALF_LOW : HALF_HIGH;
            second_q <= req_low & req_high;
        end else if (advance) begin
            half_q   <= HALF_HIGH;
            second_q <= 1'b0;
        end
    end

    // Read halves land in hold_q; the visible read data follows it only at a read's ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q      <= '0;
            read_data_q <= '0;
            overrun_q   <= 1'b0;
        end else if (sync_reset) begin
            hold_q      <= '0;
            read_data_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= strobe && (state != IDLE);
            if (state == ACCESS && timer_done && !write_q) begin
                if (half_q == HALF_HIGH) begin
                    hold_q[31:16] <= mem16_din;
                end else begin
                    hold_q[15:0] <= mem16_din;
                end
            end
            if (state == DONE && !write_q) begin
                read_data_q <= hold_q;
            end
        end
    end

    assign ext_dram_ack           = (state == DONE);
    assign busy                   = (state != IDLE);
    assign req_overrun            = overrun_q;
    assign mem16_addr             = {addr_q, half_q};
    assign ext_dram_mem_read_data = (state == DONE && !write_q) ? hold_q : read_data_q;

endmodule
